// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for the issue stage: blocks issue on RAW/WAW against in-flight writes.
// Tracks pending registers, per-register age watchdog, stall counter and orphan-writeback flag.
module hazard_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_writes,
  input  logic [4:0]          issue_write_reg,
  input  logic                issue_reads_a,
  input  logic [4:0]          issue_read_a_reg,
  input  logic                issue_reads_b,
  input  logic [4:0]          issue_read_b_reg,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [4:0]          wb_reg,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                busy,
  output logic [15:0]         stall_cycles,
  output logic                wb_orphan,
  output logic                timeout_err
);

  localparam int AW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] AGE_LIM = AW'(TIMEOUT - 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT);

  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] eff;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] next_mask;
  logic [AW-1:0]       age [NUM_REGS];
  logic                fire;
  logic                age_hit;
  logic                orphan_hit;

  always_comb begin
    wb_hit = '0;
    if (wb_valid) wb_hit[wb_reg] = 1'b1;

    // Flush squashes every in-flight write, so nothing can hazard in that cycle.
    if (flush)               eff = '0;
    else if (WB_BYPASS != 0) eff = pending_mask & ~wb_hit;
    else                     eff = pending_mask;

    issue_ready = !((issue_reads_a && eff[issue_read_a_reg]) ||
                    (issue_reads_b && eff[issue_read_b_reg]) ||
                    (issue_writes  && eff[issue_write_reg]));
    fire = issue_valid && issue_ready;

    set_vec = '0;
    if (fire && issue_writes) set_vec[issue_write_reg] = 1'b1;

    if (flush) next_mask = set_vec;
    else       next_mask = (pending_mask & ~wb_hit) | set_vec;

    age_hit = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (pending_mask[r] && (age[r] == AGE_LIM)) age_hit = 1'b1;
    end

    orphan_hit = wb_valid && !flush && !pending_mask[wb_reg];
    busy       = |pending_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_mask <= '0;
      stall_cycles <= '0;
      wb_orphan    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      pending_mask <= next_mask;
      if (issue_valid && !issue_ready && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (orphan_hit) wb_orphan   <= 1'b1;
      if (age_hit)    timeout_err <= 1'b1;
    end
  end

  // A re-set in the same cycle as its writeback starts a fresh lifetime, hence age 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) age[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (!next_mask[r] || set_vec[r]) age[r] <= '0;
        else if (age[r] != AGE_MAX)      age[r] <= age[r] + AW'(1);
      end
    end
  end

endmodule
